// File: rtl/rr_mux_arb_pkg.sv
// Shared types and sizing helpers for the round-robin arbitrated mux.
// Optional packet lock is enabled by defining RR_MUX_ARB_PKT_LOCK_EN.
package rr_mux_pkg;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Channel index width; a single channel still needs one bit to carry an index.
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// Handshake bundle between N producers, the arbitrated mux and one consumer.
// Carries in_last/out_last only when RR_MUX_ARB_PKT_LOCK_EN is defined.
interface rr_mux_arb_if
  import rr_mux_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
);
  localparam int CW = chan_w(N);

  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;
`ifdef RR_MUX_ARB_PKT_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_last
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_last
  );
`else
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );
`endif

endinterface

// File: rtl/rr_mux_arb_arbiter.sv
// Combinational round-robin arbiter: double-width masked priority encoder
// starting the search at ptr and wrapping through the second copy of req.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int CW = chan_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] gnt_idx,
  output logic          any_req
);

  logic [2*N-1:0] dbl_req;
  int             pos;
  logic           found;

  // Lower copy is masked below ptr; upper copy supplies the wrapped-around channels.
  genvar gi;
  generate
    for (gi = 0; gi < 2 * N; gi++) begin : g_dbl
      assign dbl_req[gi] = req[gi % N] & ((gi >= N) || (gi >= int'(ptr)));
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    pos   = 0;
    for (int i = 0; i < 2 * N; i++) begin
      if (!found && dbl_req[i]) begin
        found = 1'b1;
        pos   = i;
      end
    end
  end

  assign any_req = |req;
  assign gnt_idx = CW'((pos >= N) ? (pos - N) : pos);

  generate
    for (gi = 0; gi < N; gi++) begin : g_gnt
      assign gnt[gi] = any_req && (int'(gnt_idx) == gi);
    end
  endgenerate

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel W-bit round-robin mux with valid/ready handshakes and a registered output.
// Define RR_MUX_ARB_PKT_LOCK_EN to hold the grant on one channel until its last beat.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic        clk,
  input  logic        rst,
  rr_mux_arb_if.slave bus
);
  localparam int CW = chan_w(N);

  logic          load;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [CW-1:0] gnt_idx;
  logic          any_req;
  logic [CW-1:0] ptr_inc;

  logic          out_valid_reg, out_valid_next;
  logic [W-1:0]  out_data_reg,  out_data_next;
  logic [CW-1:0] out_chan_reg,  out_chan_next;
  logic [CW-1:0] ptr_reg,       ptr_next;

  assign load = !out_valid_reg || bus.out_ready;

`ifdef RR_MUX_ARB_PKT_LOCK_EN
  lock_state_e   state_reg, state_next;
  logic [CW-1:0] lock_chan_reg, lock_chan_next;
  logic          out_last_reg, out_last_next;
  logic [N-1:0]  lock_mask;

  always_comb begin
    lock_mask            = '0;
    lock_mask[lock_chan_reg] = 1'b1;
  end

  // While locked only the owning channel may request; others keep waiting.
  assign req = (state_reg == ST_LOCKED) ? (bus.in_valid & lock_mask) : bus.in_valid;
  assign bus.out_last = out_last_reg;
`else
  assign req = bus.in_valid;
`endif

  rr_arbiter #(.N(N)) u_arb (
    .req     (req),
    .ptr     (ptr_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  assign bus.in_ready = (load && !rst) ? gnt : '0;
  assign ptr_inc      = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + CW'(1);

  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_chan_next  = out_chan_reg;
    ptr_next       = ptr_reg;
`ifdef RR_MUX_ARB_PKT_LOCK_EN
    state_next     = state_reg;
    lock_chan_next = lock_chan_reg;
    out_last_next  = out_last_reg;
`endif
    if (load) begin
      if (any_req) begin
        out_valid_next = 1'b1;
        out_data_next  = bus.in_data[gnt_idx * W +: W];
        out_chan_next  = gnt_idx;
`ifdef RR_MUX_ARB_PKT_LOCK_EN
        out_last_next  = bus.in_last[gnt_idx];
        if (bus.in_last[gnt_idx]) begin
          ptr_next   = ptr_inc;
          state_next = ST_OPEN;
        end else begin
          state_next     = ST_LOCKED;
          lock_chan_next = gnt_idx;
        end
`else
        ptr_next       = ptr_inc;
`endif
      end else begin
        out_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      ptr_reg       <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_chan_reg  <= out_chan_next;
      ptr_reg       <= ptr_next;
    end
  end

`ifdef RR_MUX_ARB_PKT_LOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_OPEN;
      lock_chan_reg <= '0;
      out_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lock_chan_reg <= lock_chan_next;
      out_last_reg  <= out_last_next;
    end
  end
`endif

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_chan  = out_chan_reg;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Self-checking bench for rr_mux_arb: directed scenarios plus random traffic
// compared against a cycle-level round-robin reference model.
module tb_rr_mux_arb;
  import rr_mux_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
`ifdef RR_MUX_ARB_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux_arb_if #(.N(N), .W(W)) bus ();
  rr_mux_arb #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_ptr;
  bit         m_lock;
  int         m_lock_ch;
  bit         m_last;

  logic [7:0]   d [N];
  logic [N-1:0] v;
  logic [N-1:0] lst;
  logic [N-1:0] acc;
  logic [N-1:0] rdy;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_chan = 0; m_ptr = 0;
    m_lock = 1'b0; m_lock_ch = 0; m_last = 1'b0;
  endtask

  function automatic int model_grant();
    if (m_lock) return v[m_lock_ch] ? m_lock_ch : -1;
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic apply();
    bus.in_valid = v;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = d[i];
`ifdef RR_MUX_ARB_PKT_LOCK_EN
    bus.in_last = lst;
`endif
  endtask

  // One cycle: called at a falling edge, returns at the next falling edge.
  task automatic step(output logic [N-1:0] rdy_seen);
    int g;
    bit ld;
    apply();
    #1;
    g  = model_grant();
    ld = !m_valid || bus.out_ready;
    rdy_seen = bus.in_ready;
    check_eq("in_ready", bus.in_ready, (ld && g >= 0) ? (32'd1 << g) : 32'd0);
    acc = bus.in_ready & v;
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_data = d[g]; m_chan = g; m_last = lst[g];
        if (!LOCK_EN || lst[g]) begin
          m_ptr = (g + 1) % N; m_lock = 1'b0;
        end else begin
          m_lock = 1'b1; m_lock_ch = g;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check_eq("out_valid", bus.out_valid, m_valid);
    check_eq("out_data", bus.out_data, m_data);
    check_eq("out_chan", bus.out_chan, m_chan);
`ifdef RR_MUX_ARB_PKT_LOCK_EN
    check_eq("out_last", bus.out_last, m_last);
`endif
    if (bus.out_valid) $display("txn: chan=%0d data=%02h", bus.out_chan, bus.out_data);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, bus.out_valid, 0);
    check_eq({tag, "_data"},  bus.out_data,  0);
    check_eq({tag, "_chan"},  bus.out_chan,  0);
    check_eq({tag, "_rdy"},   bus.in_ready,  0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("rst_pulse");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    v = '0; lst = '0; acc = '0;
    for (int i = 0; i < N; i++) d[i] = 8'h00;
    bus.out_ready = 1'b0;
    apply();
    model_reset();
    #1;
    check_reset_outputs("rst_init");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single channel
    v = 4'b0100; d[2] = 8'hA5; bus.out_ready = 1'b1;
    step(rdy);
    check_eq("t2_rdy", rdy, 4'b0100);
    check_eq("t2_valid", bus.out_valid, 1);
    check_eq("t2_data", bus.out_data, 8'hA5);
    check_eq("t2_chan", bus.out_chan, 2);

    // Sparse with wrap from ptr=3
    v = 4'b0011; d[0] = 8'h30; d[1] = 8'h31;
    step(rdy);
    check_eq("t5_rdy0", rdy, 4'b0001);
    check_eq("t5_chan0", bus.out_chan, 0);
    step(rdy);
    check_eq("t5_rdy1", rdy, 4'b0010);
    check_eq("t5_chan1", bus.out_chan, 1);

    // All valid, full throughput
    pulse_reset();
    v = 4'b1111;
    for (int i = 0; i < N; i++) d[i] = 8'h10 + 8'(i);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(rdy);
      check_eq("t3_valid", bus.out_valid, 1);
      check_eq("t3_chan", bus.out_chan, k % 4);
      check_eq("t3_data", bus.out_data, 8'h10 + (k % 4));
    end
    step(rdy);
    step(rdy);
    check_eq("t4_pre", bus.out_data, 8'h11);

    // Backpressure
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(rdy);
      check_eq("t4_rdy", rdy, 4'b0000);
      check_eq("t4_hold", bus.out_data, 8'h11);
    end
    bus.out_ready = 1'b1;
    step(rdy);
    check_eq("t4_rel_rdy", rdy, 4'b0100);
    check_eq("t4_rel_chan", bus.out_chan, 2);

    // Reset asserted mid-stall takes effect before any edge
    bus.out_ready = 1'b0;
    step(rdy);
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("t1_mid");
    @(negedge clk);
    rst = 1'b0;

    // Random traffic; a valid unaccepted input usually holds its beat
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && !acc[i] && $urandom_range(0, 9) != 0)) begin
          v[i]   = 1'($urandom_range(0, 1));
          d[i]   = 8'($urandom);
          lst[i] = ($urandom_range(0, 2) == 0);
        end
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      step(rdy);
    end

`ifdef RR_MUX_ARB_PKT_LOCK_EN
    // Packet lock: channel 1 holds the grant for three beats
    pulse_reset();
    bus.out_ready = 1'b1;
    v = 4'b0110; d[2] = 8'h40; lst = 4'b0100;
    for (int b = 0; b < 3; b++) begin
      d[1]   = 8'h21 + 8'(b);
      lst[1] = (b == 2);
      step(rdy);
      check_eq("t6_chan", bus.out_chan, 1);
      check_eq("t6_last", bus.out_last, (b == 2) ? 1 : 0);
    end
    v = 4'b0100;
    step(rdy);
    check_eq("t6_next_chan", bus.out_chan, 2);
    check_eq("t6_next_data", bus.out_data, 8'h40);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-channel, W-bit multiplexer.
- Select lines are replaced by a round-robin arbiter and valid/ready handshakes on every input and on the output.
- Generalises the fixed 4:1 combinational mux to any channel count and width, and adds a registered output stage.
- Sits between multiple producers (e.g. per-lane data sources) and a single shared downstream consumer.

Parameters:
- N, 4, number of input channels (N >= 1).
- W, 8, data width per channel in bits (W >= 1).
- CW, (N > 1) ? $clog2(N) : 1, channel index width; derived, not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_ready  output  N  per-channel ready; a beat transfers on channel i when in_valid[i] && in_ready[i].
- in_data  input  N*W  packed data; channel i occupies bits [i*W +: W].
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  W  registered data.
- out_chan  output  CW  index of the channel the held beat came from.

Behaviour:
- Reset, asynchronous on rst high:
  - out_valid=0, out_data=0, out_chan=0, ptr=0.
  - in_ready=0 while rst is high.
  - A beat in flight is discarded.
- Definitions:
  - load = !out_valid || out_ready. The output register is empty, or its beat leaves this cycle.
  - ptr (CW bits) is the highest-priority channel.
  - Search order: ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The first i in that order with in_valid[i]=1 wins; call it g.
- Grant:
  - in_ready[g] = load.
  - All other in_ready bits are 0.
  - At most one in_ready bit is high in any cycle.
  - in_ready is combinational from in_valid, ptr, out_valid and out_ready.
  - A producer must not make in_valid depend on in_ready.
- On a clock edge with load and any in_valid:
  - out_data <= in_data[g].
  - out_chan <= g.
  - out_valid <= 1.
  - ptr <= (g == N-1) ? 0 : g+1, so the pointer wraps at N-1.
- On a clock edge with load and no in_valid:
  - out_valid <= 0.
  - out_data and out_chan hold their values; they are don't-care while out_valid=0 but must not be X.
  - ptr holds.
- On a clock edge with !load (stall):
  - All registers hold.
  - All in_ready are 0.
- Latency and throughput:
  - An input beat accepted at edge k is visible on out_* after edge k, i.e. 1-cycle latency.
  - Sustained throughput is 1 beat/cycle when out_ready=1.
- Fairness:
  - With all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,...
  - Each channel waits at most N-1 grants.
- Input stability:
  - A channel that drops in_valid without being granted loses nothing.
  - A valid input must hold its data until accepted.
- N=1: the arbiter degenerates to a pass-through; ptr stays 0.
- Reset asserted mid-stall: out_valid drops immediately (asynchronously); the held beat is lost by design.

Optional Feature:
- Macro: RR_MUX_ARB_PKT_LOCK_EN.
- Defined:
  - Adds ports in_last (input, N) and out_last (output, 1).
  - out_last is registered alongside out_data and resets to 0.
  - After a granted beat with in_last[g]=0, the arbiter is locked to g; no other channel gets in_ready until channel g transfers a beat with in_last=1.
  - While locked, ptr does not advance. On the last beat, ptr <= g+1 (with wrap) and the lock clears.
  - While locked and in_valid[g]=0, out_valid drops at the next load edge; other channels still wait.
  - Reset clears the lock.
- Undefined:
  - No last ports.
  - Arbitration is per beat, as above.

Decomposition:
- Package rr_mux_pkg:
  - function chan_w(n), returning max(1, $clog2(n)).
  - localparam default widths.
- Sub-module rr_arbiter (N): inputs req[N] and ptr[CW]; outputs one-hot gnt[N], index gnt_idx[CW] and any_req.
  - Purely combinational: double-width masked priority encoder.
  - The lock and ptr registers stay in rr_mux_arb.

Test Plan (N=4, W=8):
1. Reset -> with rst=1 mid-run, out_valid=0, out_data=0x00, out_chan=0 and in_ready=4'b0000 in the same cycle, before any edge.
2. Single channel: in_valid=4'b0100, in_data[2]=0xA5, out_ready=1 -> in_ready=4'b0100; on the next cycle out_valid=1, out_data=0xA5, out_chan=2; ptr=3.
3. All valid with channel i holding data 0x10+i, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3; out_data 0x10,0x11,0x12,0x13 repeating; one beat per cycle.
4. Backpressure: out valid with data 0x11, out_ready=0 for 3 cycles, all inputs valid -> in_ready=0 throughout, out_data stays 0x11; out_ready=1 -> the next beat is from channel 2.
5. Sparse and wrap: ptr=3, in_valid=4'b0011 -> channel 0 is granted and ptr becomes 1; then in_valid=4'b0011 -> channel 1 is granted.
6. With RR_MUX_ARB_PKT_LOCK_EN, channel 1 sends 3 beats (last on the 3rd) while channel 2 is valid -> out_chan=1,1,1 with out_last=0,0,1, then out_chan=2.
